// File: rtl/load_store_unit.sv
// Load/store unit between the core and a single-ported, 32-bit, word-addressed data memory.
// Handles sub-word loads with sign/zero extension and sub-word stores as read-modify-write.
module load_store_unit (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] endereco,
    output logic [31:0] write_data,
    input  logic [31:0] read_data
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        RMW_WR = 3'd3,
        STORE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t      state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic        misaligned;
    logic [4:0]  lane_sh;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign req_ready = (state == IDLE);

    // Alignment is judged on the live request so the accept edge can route straight to DONE.
    always_comb begin
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        lane_sh = {r_addr[1:0], 3'b000};
        lane_b  = read_data[lane_sh +: 8];
        lane_h  = r_addr[1] ? read_data[31:16] : read_data[15:0];
        case (r_size)
            2'b00:   load_data = {{24{~r_unsigned & lane_b[7]}}, lane_b};
            2'b01:   load_data = {{16{~r_unsigned & lane_h[15]}}, lane_h};
            default: load_data = read_data;
        endcase
        merged = read_data;
        case (r_size)
            2'b00: merged[lane_sh +: 8] = r_wdata[7:0];
            2'b01: begin
                if (r_addr[1]) merged[31:16] = r_wdata[15:0];
                else           merged[15:0]  = r_wdata[15:0];
            end
            default: merged = r_wdata;
        endcase
    end

    // write_data doubles as the merge buffer: the merged word is latched at the RMW_RD edge
    // and presented unchanged during RMW_WR.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            r_write    <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            endereco   <= 32'd0;
            write_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        if (misaligned) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                        end else if (!req_write) begin
                            state    <= LOAD;
                            MemRead  <= 1'b1;
                            endereco <= {req_addr[31:2], 2'b00};
                        end else if (req_size == 2'b10) begin
                            state      <= STORE;
                            MemWrite   <= 1'b1;
                            endereco   <= {req_addr[31:2], 2'b00};
                            write_data <= req_wdata;
                        end else begin
                            state    <= RMW_RD;
                            MemRead  <= 1'b1;
                            endereco <= {req_addr[31:2], 2'b00};
                        end
                    end
                end
                LOAD: begin
                    MemRead    <= 1'b0;
                    endereco   <= 32'd0;
                    resp_rdata <= r_write ? 32'd0 : load_data;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                RMW_RD: begin
                    MemRead    <= 1'b0;
                    MemWrite   <= 1'b1;
                    write_data <= merged;
                    endereco   <= {r_addr[31:2], 2'b00};
                    state      <= RMW_WR;
                end
                RMW_WR, STORE: begin
                    MemWrite   <= 1'b0;
                    write_data <= 32'd0;
                    endereco   <= 32'd0;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    resp_rdata <= 32'd0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit data and 32-bit address.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset:
  clock        input   1   rising-edge clock, shared with data memory
  reset_n      input   1   asynchronous active-low reset
  req_valid    input   1   core presents an access request
  req_ready    output  1   block can accept a request (high only in IDLE)
  req_write    input   1   1 = store, 0 = load
  req_size     input   2   00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned)
  req_unsigned input   1   loads: 1 = zero-extend, 0 = sign-extend
  req_addr     input   32  byte address
  req_wdata    input   32  store data, right-justified
  resp_valid   output  1   one-cycle response pulse
  resp_rdata   output  32  extended load data; 0 for stores and errors
  resp_error   output  1   misaligned or reserved-size request
  MemRead      output  1   data memory read enable
  MemWrite     output  1   data memory write enable, written on next rising edge
  endereco     output  32  word-aligned memory address
  write_data   output  32  memory write word
  read_data    input   32  memory read word, combinational, valid while MemRead=1

Function
REQ-003 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; the block SHALL capture all req_* fields into internal registers at that edge.
REQ-004 The FSM SHALL have the states IDLE, LOAD, RMW_RD, RMW_WR, STORE, DONE.
REQ-005 On accept from IDLE, the FSM SHALL move to:
  - DONE with error flag set, if misaligned (half with addr[0]=1, word with addr[1:0]!=00, size 11);
  - LOAD, for a load;
  - STORE, for a word store;
  - RMW_RD, for a byte or halfword store.
REQ-006 LOAD SHALL assert MemRead=1 and latch the selected bytes of read_data at the rising edge; the next state SHALL be DONE.
REQ-007 RMW_RD SHALL assert MemRead=1 and latch read_data into a merge buffer; the next state SHALL be RMW_WR.
REQ-008 RMW_WR SHALL assert MemWrite=1 with write_data = merge buffer with target lanes replaced by the low byte/half of req_wdata; the next state SHALL be DONE.
REQ-009 STORE SHALL assert MemWrite=1 with write_data = req_wdata; the next state SHALL be DONE.
REQ-010 DONE SHALL assert resp_valid=1 for exactly one cycle, then return to IDLE; resp_error SHALL be valid only while resp_valid=1.
REQ-011 Lane mapping SHALL be little-endian: the byte at addr[1:0]=k occupies bits [8k+7:8k]; a halfword at addr[1]=h occupies bits [16h+15:16h].
REQ-012 endereco SHALL be {addr[31:2],2'b00} in LOAD/RMW_RD/RMW_WR/STORE, and 0 otherwise.
REQ-013 write_data SHALL be 0 whenever MemWrite=0.
REQ-014 MemRead and MemWrite SHALL never be high in the same cycle, and SHALL never be high in IDLE or DONE.
REQ-015 Latency from the accept edge to resp_valid high SHALL be: error 1 cycle; load 2 cycles; word store 2 cycles; byte/half store 3 cycles.
REQ-016 A misaligned request SHALL cause no MemRead or MemWrite assertion.
REQ-017 req_valid while req_ready=0 SHALL be ignored; the core holds its request until it is accepted.

Reset
REQ-018 reset_n=0 SHALL asynchronously force IDLE, all registers to 0, and MemRead=0, MemWrite=0, resp_valid=0, resp_error=0, endereco=0, write_data=0; req_ready SHALL be 1.
REQ-019 A reset asserted mid-operation SHALL abort the access with no response; no MemWrite SHALL occur after reset asserts.

Verification
REQ-020 Word store addr=0x10, wdata=0xDEADBEEF, then word load addr=0x10 -> one MemWrite cycle with endereco=0x10, then resp_rdata=0xDEADBEEF 2 cycles after accept.
REQ-021 Memory word 0x11223344, byte store addr=0x12, wdata=0xAA -> RMW_RD then RMW_WR with write_data=0x11AA3344, resp_valid 3 cycles after accept.
REQ-022 Memory word 0x80FF7F01: byte load addr=0x3 signed -> 0xFFFFFF80; same load unsigned -> 0x00000080; half load addr=0x0 signed -> 0x00007F01.
REQ-023 Half load addr=0x5 and word store addr=0x6 -> resp_error=1 one cycle after accept, MemRead=MemWrite=0 throughout.
REQ-024 reset_n pulsed low during RMW_RD of a byte store -> memory word unchanged, no resp_valid, req_ready=1 after release.
REQ-025 Back-to-back requests with req_valid held high -> each accepted only in IDLE, and responses are in order with no overlap.
